// File: rtl/fp_pkg.sv
// Shared FP32 constants and converter state encoding.
// Latency: n/a (package only).
// Backpressure: n/a.
package fp_pkg;
  localparam int          FP32_BIAS     = 127;
  localparam int          FP32_EXP_W    = 8;
  localparam int          FP32_MAN_W    = 23;
  localparam logic [31:0] FP32_POS_ZERO = 32'h0000_0000;

  // Biased exponent of a value whose MSB sits at bit 31 of the working magnitude.
  localparam logic [7:0]  CVT_EXP_TOP   = 8'(FP32_BIAS + 31);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } cvt_state_t;
endpackage

// File: rtl/fp_round_rne.sv
// Combinational IEEE-754 round-to-nearest-even of a truncated fp32 mantissa.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; follows its inputs.
// Ports: i_man/i_exp = truncated mantissa and biased exponent, i_g/i_s = guard and sticky,
//        o_man/o_exp = rounded fields, o_inexact = any discarded bit was nonzero.
module fp_round_rne
  import fp_pkg::*;
(
  input  logic [FP32_MAN_W-1:0] i_man,
  input  logic [FP32_EXP_W-1:0] i_exp,
  input  logic                  i_g,
  input  logic                  i_s,
  output logic [FP32_MAN_W-1:0] o_man,
  output logic [FP32_EXP_W-1:0] o_exp,
  output logic                  o_inexact
);
  logic            w_up;
  logic [FP32_MAN_W:0] w_sum;

  // Ties go to the even mantissa, hence the man[0] term.
  assign w_up      = i_g & (i_s | i_man[0]);
  assign w_sum     = {1'b0, i_man} + {{FP32_MAN_W{1'b0}}, w_up};
  assign o_inexact = i_g | i_s;

  always_comb begin
    o_man = w_sum[FP32_MAN_W-1:0];
    o_exp = i_exp;
    // Carry out of the mantissa: 1.111..1 rounded up becomes 1.0 x 2^(e+1).
    if (w_sum[FP32_MAN_W]) begin
      o_man = '0;
      o_exp = i_exp + 8'd1;
    end
  end
endmodule

// File: rtl/fp_cvt_s_w_seq.sv
// Multi-cycle int32/uint32 -> fp32 converter: iterative left-normalise then RNE rounding.
// Latency: zero operand reaches DONE on the accept edge; otherwise N+2 edges after accept (N = shift steps).
// Backpressure: o_ready only in IDLE; result held in DONE with o_valid high until i_ready.
// Ports: i_clk/i_rst (async, active-high), i_valid/o_ready/i_data/i_unsigned operand side,
//        o_valid/i_ready/o_data/o_inexact result side.
module fp_cvt_s_w_seq
  import fp_pkg::*;
#(
  parameter int SHIFT_STEP = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_data,
  input  logic        i_unsigned,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_data,
  output logic        o_inexact
);
  localparam logic [7:0] STEP_W = 8'(SHIFT_STEP);

  cvt_state_t  r_state, w_next;
  logic        r_sign;
  logic [31:0] r_mag;
  logic [7:0]  r_shift;
  logic [31:0] r_data;
  logic        r_inexact;

  logic        w_in_sign;
  logic [31:0] w_in_mag;
  logic        w_top_zero;
  logic [7:0]  w_exp;
  logic [22:0] w_rnd_man;
  logic [7:0]  w_rnd_exp;
  logic        w_rnd_inexact;

  assign w_in_sign  = ~i_unsigned & i_data[31];
  // Two's-complement negate; 0x80000000 maps to itself, which is the correct uint magnitude.
  assign w_in_mag   = w_in_sign ? (~i_data + 32'd1) : i_data;
  assign w_top_zero = (r_mag >> (32 - SHIFT_STEP)) == 32'd0;
  assign w_exp      = CVT_EXP_TOP - r_shift;

  fp_round_rne u_round (
    .i_man     (r_mag[30:8]),
    .i_exp     (w_exp),
    .i_g       (r_mag[7]),
    .i_s       (|r_mag[6:0]),
    .o_man     (w_rnd_man),
    .o_exp     (w_rnd_exp),
    .o_inexact (w_rnd_inexact)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    o_ready = 1'b0;
    o_valid = 1'b0;
    case (r_state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) w_next = (w_in_mag == 32'd0) ? DONE : NORM;
      end
      NORM:  if (r_mag[31]) w_next = ROUND;
      ROUND: w_next = DONE;
      DONE: begin
        o_valid = 1'b1;
        if (i_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sign    <= 1'b0;
      r_mag     <= '0;
      r_shift   <= '0;
      r_data    <= FP32_POS_ZERO;
      r_inexact <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (i_valid) begin
          r_sign    <= w_in_sign;
          r_mag     <= w_in_mag;
          r_shift   <= '0;
          // Zero bypasses normalisation; always +0 regardless of operand sign.
          r_data    <= FP32_POS_ZERO;
          r_inexact <= 1'b0;
        end
        NORM: if (!r_mag[31]) begin
          if (w_top_zero) begin
            r_mag   <= r_mag << SHIFT_STEP;
            r_shift <= r_shift + STEP_W;
          end else begin
            r_mag   <= r_mag << 1;
            r_shift <= r_shift + 8'd1;
          end
        end
        ROUND: begin
          r_data    <= {r_sign, w_rnd_exp, w_rnd_man};
          r_inexact <= w_rnd_inexact;
        end
        default: ;
      endcase
    end
  end

  assign o_data    = r_data;
  assign o_inexact = r_inexact;
endmodule
